// File: rtl/boot_pkg.sv
// boot_pkg: shared types and constants for the boot loader.
//   boot_state_t   - loader FSM states
//   BYTES_PER_WORD - stream bytes per instruction word
//   WORD_BITS      - assembled word width
//   max_depth()    - number of words addressable with a given address width
package boot_pkg;

  typedef enum logic [2:0] {
    LEN0,
    LEN1,
    DATA,
    CSUM,
    DONE,
    ERR
  } boot_state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_BITS      = BYTES_PER_WORD * 8;

  function automatic int unsigned max_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/boot_word_pack.sv
// boot_word_pack: little-endian byte-to-word assembler.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   clear       - synchronous clear of byte index and partial word
//   byte_en     - byte_in is consumed this cycle
//   byte_in     - incoming byte
//   word        - assembled word; valid while word_ready is high
//   word_ready  - high in the cycle the 4th byte of a word is consumed
// The 4th byte is not stored: the word is formed combinationally from it so
// the parent can register the complete word on the same edge.
module boot_word_pack
  import boot_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 byte_en,
  input  logic [7:0]           byte_in,
  output logic [WORD_BITS-1:0] word,
  output logic                 word_ready
);

  logic [1:0]            idx;
  logic [WORD_BITS-9:0]  low;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      low <= '0;
    end else if (clear) begin
      idx <= '0;
      low <= '0;
    end else if (byte_en) begin
      case (idx)
        2'd0:    low[7:0]   <= byte_in;
        2'd1:    low[15:8]  <= byte_in;
        2'd2:    low[23:16] <= byte_in;
        default: ;
      endcase
      idx <= idx + 2'd1;
    end
  end

  assign word       = {byte_in, low};
  assign word_ready = byte_en && (idx == 2'd3);

endmodule

// File: rtl/boot_loader.sv
// boot_loader: receives a program image as a little-endian byte stream
// (2-byte word count N, 4*N payload bytes, optional XOR checksum byte) and
// writes it word by word into instruction memory, holding the core in reset
// until the load completes.
// Build option: define BOOT_LOADER_CSUM_EN to expect and verify a trailing
// checksum byte; otherwise DONE follows the final write directly.
// Ports:
//   i_clk, i_rst   - clock, asynchronous active-high reset
//   i_byte/i_valid - stream byte and its valid; o_ready accepts it
//   i_restart      - re-arms the loader from DONE or ERR
//   o_imem_we/o_imem_addr/o_imem_wdata - instruction memory write port
//   o_core_rst     - reset to the pipeline core, low only in DONE
//   o_done/o_error - load finished / load failed (sticky until restart)
module boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH = 32,
  parameter int unsigned P_ADDR_WIDTH = 10,
  parameter int unsigned P_LEN_WIDTH  = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [7:0]              i_byte,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_restart,
  output logic                    o_imem_we,
  output logic [P_ADDR_WIDTH-1:0] o_imem_addr,
  output logic [P_DATA_WIDTH-1:0] o_imem_wdata,
  output logic                    o_core_rst,
  output logic                    o_done,
  output logic                    o_error
);

  boot_state_t            state;
  logic [P_LEN_WIDTH-1:0] len;
  logic [P_LEN_WIDTH-1:0] len_full;
  logic [P_LEN_WIDTH-1:0] word_cnt;
  logic [P_LEN_WIDTH-1:0] cnt_next;
  logic                   accept;
  logic                   pack_en;
  logic                   pack_clear;
  logic                   word_ready;
  logic [WORD_BITS-1:0]   word;
`ifdef BOOT_LOADER_CSUM_EN
  logic [7:0]             csum;
`endif

  assign accept     = i_valid && o_ready;
  assign pack_en    = accept && (state == DATA);
  assign pack_clear = i_restart && ((state == DONE) || (state == ERR));
  assign len_full   = P_LEN_WIDTH'({i_byte, len[7:0]});
  assign cnt_next   = word_cnt + P_LEN_WIDTH'(1);

  boot_word_pack u_pack (
    .clk        (i_clk),
    .rst        (i_rst),
    .clear      (pack_clear),
    .byte_en    (pack_en),
    .byte_in    (i_byte),
    .word       (word),
    .word_ready (word_ready)
  );

  // Status outputs are registered alongside the state so o_ready, o_done,
  // o_error and o_core_rst always reflect the state they are entering.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= LEN0;
      len          <= '0;
      word_cnt     <= '0;
`ifdef BOOT_LOADER_CSUM_EN
      csum         <= '0;
`endif
      o_ready      <= 1'b1;
      o_imem_we    <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_wdata <= '0;
      o_core_rst   <= 1'b1;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
    end else begin
      o_imem_we <= 1'b0;
      case (state)
        LEN0: begin
          if (accept) begin
            len   <= P_LEN_WIDTH'(i_byte);
            state <= LEN1;
          end
        end
        LEN1: begin
          if (accept) begin
            len <= len_full;
            if (32'(len_full) > max_depth(P_ADDR_WIDTH)) begin
              state   <= ERR;
              o_ready <= 1'b0;
              o_error <= 1'b1;
            end else if (len_full == '0) begin
`ifdef BOOT_LOADER_CSUM_EN
              state      <= CSUM;
`else
              state      <= DONE;
              o_ready    <= 1'b0;
              o_done     <= 1'b1;
              o_core_rst <= 1'b0;
`endif
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
`ifdef BOOT_LOADER_CSUM_EN
            csum <= csum ^ i_byte;
`endif
            if (word_ready) begin
              o_imem_we    <= 1'b1;
              o_imem_addr  <= word_cnt[P_ADDR_WIDTH-1:0];
              o_imem_wdata <= P_DATA_WIDTH'(word);
              word_cnt     <= cnt_next;
              // Leave DATA on the final write so the address never advances
              // past the last word.
              if (cnt_next == len) begin
`ifdef BOOT_LOADER_CSUM_EN
                state      <= CSUM;
`else
                state      <= DONE;
                o_ready    <= 1'b0;
                o_done     <= 1'b1;
                o_core_rst <= 1'b0;
`endif
              end
            end
          end
        end
`ifdef BOOT_LOADER_CSUM_EN
        CSUM: begin
          if (accept) begin
            o_ready <= 1'b0;
            if (i_byte == csum) begin
              state      <= DONE;
              o_done     <= 1'b1;
              o_core_rst <= 1'b0;
            end else begin
              state   <= ERR;
              o_error <= 1'b1;
            end
          end
        end
`endif
        DONE, ERR: begin
          if (i_restart) begin
            state      <= LEN0;
            len        <= '0;
            word_cnt   <= '0;
`ifdef BOOT_LOADER_CSUM_EN
            csum       <= '0;
`endif
            o_ready    <= 1'b1;
            o_core_rst <= 1'b1;
            o_done     <= 1'b0;
            o_error    <= 1'b0;
          end
        end
        default: begin
          state <= LEN0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed self-checking bench for boot_loader.
// Works in both builds (BOOT_LOADER_CSUM_EN defined or not).
module tb_boot_loader;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [7:0]  i_byte = '0;
  logic        i_valid = 1'b0;
  logic        i_restart = 1'b0;
  logic        o_ready;
  logic        o_imem_we;
  logic [9:0]  o_imem_addr;
  logic [31:0] o_imem_wdata;
  logic        o_core_rst;
  logic        o_done;
  logic        o_error;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // write monitor (captures what instruction memory would receive)
  logic [31:0] mem [0:1023];
  int unsigned wr_count = 0;
  int unsigned addr_seq_err = 0;

  boot_loader #(
    .P_DATA_WIDTH (32),
    .P_ADDR_WIDTH (10),
    .P_LEN_WIDTH  (16)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_byte       (i_byte),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_restart    (i_restart),
    .o_imem_we    (o_imem_we),
    .o_imem_addr  (o_imem_addr),
    .o_imem_wdata (o_imem_wdata),
    .o_core_rst   (o_core_rst),
    .o_done       (o_done),
    .o_error      (o_error)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_imem_we === 1'b1) begin
      if (o_imem_addr != wr_count[9:0]) addr_seq_err++;
      mem[o_imem_addr] = o_imem_wdata;
      wr_count++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Presents a byte and returns #1 after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b);
    bit taken = 1'b0;
    i_byte  = b;
    i_valid = 1'b1;
    for (int k = 0; k < 50 && !taken; k++) begin
      taken = (o_ready === 1'b1);
      @(posedge i_clk);
      #1;
    end
    i_valid = 1'b0;
    if (!taken) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int unsigned gap);
    logic [31:0] t;
    t = w;
    for (int b = 0; b < 4; b++) begin
      send_byte(t[7:0]);
      t = t >> 8;
      if (b < 3) idle(gap);
    end
  endtask

  task automatic pulse_restart();
    i_restart = 1'b1;
    @(posedge i_clk);
    #1;
    i_restart = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"},   32'(o_ready),      32'd1);
    check({tag, "_we"},      32'(o_imem_we),    32'd0);
    check({tag, "_addr"},    32'(o_imem_addr),  32'd0);
    check({tag, "_wdata"},   o_imem_wdata,      32'd0);
    check({tag, "_corerst"}, 32'(o_core_rst),   32'd1);
    check({tag, "_done"},    32'(o_done),       32'd0);
    check({tag, "_error"},   32'(o_error),      32'd0);
  endtask

  initial begin
    // ---------------- reset state
    idle(2);
    check_reset_vals("rst");
    i_rst = 1'b0;
    idle(1);
    check_reset_vals("rst_rel");

    // ---------------- image 1: two words, no gaps
    wr_count = 0; addr_seq_err = 0;
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(32'h00500013, 0);
    check("img1_w0_we",    32'(o_imem_we),   32'd1);
    check("img1_w0_addr",  32'(o_imem_addr), 32'd0);
    check("img1_w0_data",  o_imem_wdata,     32'h00500013);
    send_word(32'h00100093, 0);
    check("img1_w1_we",    32'(o_imem_we),   32'd1);
    check("img1_w1_addr",  32'(o_imem_addr), 32'd1);
    check("img1_w1_data",  o_imem_wdata,     32'h00100093);
`ifdef BOOT_LOADER_CSUM_EN
    check("img1_pre_done", 32'(o_done),      32'd0);
    check("img1_pre_rdy",  32'(o_ready),     32'd1);
    send_byte(8'hC0); // 13^00^50^00^93^00^10^00
`endif
    check("img1_done",     32'(o_done),      32'd1);
    check("img1_corerst",  32'(o_core_rst),  32'd0);
    check("img1_ready",    32'(o_ready),     32'd0);
    check("img1_error",    32'(o_error),     32'd0);
    idle(1);
    check("img1_wcount",   wr_count,         32'd2);

    // restart reasserts core reset and re-arms
    pulse_restart();
    check("rs1_corerst", 32'(o_core_rst), 32'd1);
    check("rs1_done",    32'(o_done),     32'd0);
    check("rs1_ready",   32'(o_ready),    32'd1);

`ifdef BOOT_LOADER_CSUM_EN
    // ---------------- bad checksum
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(32'h00500013, 0);
    send_word(32'h00100093, 0);
    send_byte(8'hC1);
    idle(1);
    check("bad_done",    32'(o_done),     32'd0);
    check("bad_error",   32'(o_error),    32'd1);
    check("bad_corerst", 32'(o_core_rst), 32'd1);
    check("bad_ready",   32'(o_ready),    32'd0);
    pulse_restart();
    check("rs2_error",   32'(o_error),    32'd0);
`endif

    // ---------------- oversize N = 0x0401
    wr_count = 0;
    send_byte(8'h01);
    send_byte(8'h04);
    check("ovr_error",   32'(o_error),    32'd1);
    check("ovr_ready",   32'(o_ready),    32'd0);
    check("ovr_corerst", 32'(o_core_rst), 32'd1);
    // restart is the only way out; a valid byte here must be ignored
    i_byte = 8'h55; i_valid = 1'b1;
    idle(3);
    i_valid = 1'b0;
    check("ovr_sticky",  32'(o_error),    32'd1);
    check("ovr_wcount",  wr_count,        32'd0);
    pulse_restart();

    // ---------------- N = 0
    send_byte(8'h00);
    send_byte(8'h00);
`ifdef BOOT_LOADER_CSUM_EN
    send_byte(8'h00);
`endif
    check("n0_done",     32'(o_done),     32'd1);
    check("n0_corerst",  32'(o_core_rst), 32'd0);
    pulse_restart();

    // ---------------- N = 0x400 (full depth), word i = A5000000 | i
    wr_count = 0; addr_seq_err = 0;
    send_byte(8'h00);
    send_byte(8'h04);
    for (int i = 0; i < 1024; i++) send_word(32'hA5000000 | 32'(i), 0);
    check("full_last_addr", 32'(o_imem_addr), 32'h3FF);
    check("full_last_data", o_imem_wdata,     32'hA50003FF);
`ifdef BOOT_LOADER_CSUM_EN
    send_byte(8'h00); // every payload byte column cancels out
`endif
    idle(2);
    check("full_done",     32'(o_done),      32'd1);
    check("full_wcount",   wr_count,         32'd1024);
    check("full_addr_seq", addr_seq_err,     32'd0);
    check("full_hold_addr",32'(o_imem_addr), 32'h3FF);
    check("full_mem0",     mem[0],           32'hA5000000);
    check("full_mem200",   mem[512],         32'hA5000200);
    pulse_restart();

    // ---------------- image 1 with stalls, including mid-word
    wr_count = 0; addr_seq_err = 0;
    mem[0] = '0; mem[1] = '0;
    send_byte(8'h02);
    idle(3);
    send_byte(8'h00);
    send_word(32'h00500013, 2);
    idle(1);
    send_word(32'h00100093, 5);
`ifdef BOOT_LOADER_CSUM_EN
    idle(4);
    send_byte(8'hC0);
`endif
    idle(1);
    check("gap_mem0",   mem[0],       32'h00500013);
    check("gap_mem1",   mem[1],       32'h00100093);
    check("gap_wcount", wr_count,     32'd2);
    check("gap_seq",    addr_seq_err, 32'd0);
    check("gap_done",   32'(o_done),  32'd1);
    pulse_restart();

    // ---------------- reset mid-DATA after 3 words and half a word
    send_byte(8'h05);
    send_byte(8'h00);
    send_word(32'h11111111, 0);
    send_word(32'h22222222, 0);
    send_word(32'h33333333, 0);
    send_byte(8'h44);
    send_byte(8'h44);
    i_rst = 1'b1;
    #2;
    check_reset_vals("midrst");
    i_rst = 1'b0;
    idle(1);
    check_reset_vals("midrst_rel");

    // reload after reset; then restart from DONE and reload again
    for (int pass = 0; pass < 2; pass++) begin
      wr_count = 0; addr_seq_err = 0;
      send_byte(8'h02);
      send_byte(8'h00);
      send_word(32'h00500013, 0);
      check("reload_addr0", 32'(o_imem_addr), 32'd0);
      check("reload_data0", o_imem_wdata,     32'h00500013);
      send_word(32'h00100093, 0);
`ifdef BOOT_LOADER_CSUM_EN
      send_byte(8'hC0);
`endif
      check("reload_done",  32'(o_done),      32'd1);
      pulse_restart();
      check("reload_corerst", 32'(o_core_rst), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
